// File: rtl/bcd_conv_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// START/DONE handshake matches the upstream divider; the last result is held while converting.
module bcd_conv_seq #(
    parameter int unsigned LEN    = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [LEN-1:0]        BIN,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic [DIGITS-1:0]     BLANK
);

    localparam int unsigned SLEN = $clog2(LEN + 1);
    localparam int unsigned CW   = SLEN + 1;
    localparam int unsigned BW   = 4 * DIGITS;

    function automatic logic [127:0] pow10(input int unsigned n);
        logic [127:0] r;
        r = 128'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 128'd10;
        end
        return r;
    endfunction

    localparam logic [127:0] MAXV = (128'd1 << LEN) - 128'd1;

    if (!(pow10(DIGITS) > MAXV)) begin : g_digits_too_few
        $error("bcd_conv_seq: DIGITS too small to hold 2**LEN-1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [LEN-1:0]      sh_bin_q, sh_bin_d;
    logic [BW-1:0]       sh_bcd_q, sh_bcd_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [DIGITS-1:0]   blank_q, blank_d;

    logic [BW-1:0]       adj;
    logic [BW+LEN-1:0]   shifted;
    logic [BW-1:0]       step_bcd;
    logic [LEN-1:0]      step_bin;
    logic [DIGITS-1:0]   step_blank;
    logic                zero_run;

    // One double-dabble step: per-nibble add-3 (no carry between digits), then shift.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sh_bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = sh_bcd_q[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = sh_bcd_q[4*i +: 4];
            end
        end
        shifted  = {adj, sh_bin_q} << 1;
        step_bcd = shifted[BW+LEN-1 -: BW];
        step_bin = shifted[LEN-1:0];
    end

    // Leading-zero mask, scanned from the most significant digit down; digit 0 never blanks.
    always_comb begin
        step_blank = '0;
        zero_run   = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            zero_run = zero_run & (step_bcd[4*(DIGITS-1-k) +: 4] == 4'd0);
            step_blank[DIGITS-1-k] = zero_run & (k != DIGITS - 1);
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sh_bin_d = sh_bin_q;
        sh_bcd_d = sh_bcd_q;
        bcd_d    = bcd_q;
        blank_d  = blank_q;
        if (START) begin
            state_d  = RUN;
            count_d  = CW'(LEN);
            sh_bin_d = BIN;
            sh_bcd_d = '0;
        end else if (state_q == RUN) begin
            sh_bin_d = step_bin;
            sh_bcd_d = step_bcd;
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                state_d = IDLE;
                bcd_d   = step_bcd;
                blank_d = step_blank;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            count_q  <= '0;
            sh_bin_q <= '0;
            sh_bcd_q <= '0;
            bcd_q    <= '0;
            blank_q  <= ~DIGITS'(1);
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sh_bin_q <= sh_bin_d;
            sh_bcd_q <= sh_bcd_d;
            bcd_q    <= bcd_d;
            blank_q  <= blank_d;
        end
    end

    assign DONE  = (state_q == IDLE);
    assign BCD   = bcd_q;
    assign BLANK = blank_q;

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed + random bench for bcd_conv_seq; expected digits come from decimal arithmetic.
module tb_bcd_conv_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [15:0] BIN = '0;
    logic        DONE;
    logic [19:0] BCD;
    logic [4:0]  BLANK;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [19:0] exp_bcd;
    logic [4:0]  exp_blank;

    bcd_conv_seq #(.LEN(16), .DIGITS(5)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .BIN   (BIN),
        .DONE  (DONE),
        .BCD   (BCD),
        .BLANK (BLANK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int unsigned v);
        logic [4:0] b;
        int unsigned p;
        b = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            b[i] = (i > 0) && (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Runs while DONE is low, checking the previous result is held each cycle.
    task automatic wait_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            check("busy_done_low", 64'(DONE), 64'd0);
            check("busy_bcd_hold", 64'(BCD), 64'(exp_bcd));
            check("busy_blank_hold", 64'(BLANK), 64'(exp_blank));
            tick();
        end
    endtask

    task automatic finish_check(input int unsigned v);
        exp_bcd   = ref_bcd(v);
        exp_blank = ref_blank(v);
        check("done_high", 64'(DONE), 64'd1);
        check("result_bcd", 64'(BCD), 64'(exp_bcd));
        check("result_blank", 64'(BLANK), 64'(exp_blank));
    endtask

    task automatic convert(input logic [15:0] v, input logic [15:0] bin_after);
        BIN   = v;
        START = 1'b1;
        tick();
        START = 1'b0;
        BIN   = bin_after;
        wait_cycles(15);
        tick();
        finish_check(int'(v));
    endtask

    initial begin
        logic [15:0] sweep [8];
        sweep = '{16'd65535, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd9999, 16'd10000};

        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        exp_bcd   = '0;
        exp_blank = 5'b11110;
        check("reset_done", 64'(DONE), 64'd1);
        check("reset_bcd", 64'(BCD), 64'd0);
        check("reset_blank", 64'(BLANK), 64'(5'b11110));

        convert(16'd0, 16'd0);
        check("zero_blank_const", 64'(BLANK), 64'(5'b11110));

        foreach (sweep[i]) convert(sweep[i], sweep[i]);
        check("max_bcd_const", 64'(ref_bcd(65535)), 64'(20'h65535));

        for (int r = 0; r < 20; r++) begin
            convert(16'($urandom), 16'($urandom));
        end

        convert(16'd1234, 16'd777);
        check("bin_change_bcd", 64'(BCD), 64'(20'h01234));
        check("bin_change_blank", 64'(BLANK), 64'(5'b10000));

        convert(16'd42, 16'd42);
        convert(16'd500, 16'd500);
        check("hold_then_500", 64'(BCD), 64'(20'h00500));

        // Restart at cycle 8 of a 300 conversion.
        BIN = 16'd300;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_cycles(7);
        BIN = 16'd7;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_cycles(15);
        tick();
        finish_check(7);
        check("restart_bcd", 64'(BCD), 64'(20'h00007));
        check("restart_blank", 64'(BLANK), 64'(5'b11110));

        // Reset during a 999 conversion.
        BIN = 16'd999;
        START = 1'b1;
        tick();
        START = 1'b0;
        wait_cycles(4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_bcd   = '0;
        exp_blank = 5'b11110;
        check("abort_done", 64'(DONE), 64'd1);
        check("abort_bcd", 64'(BCD), 64'd0);
        check("abort_blank", 64'(BLANK), 64'(5'b11110));
        tick();
        check("abort_idle_done", 64'(DONE), 64'd1);

        convert(16'd12345, 16'd0);
        check("post_abort_bcd", 64'(BCD), 64'(20'h12345));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
